// File: rtl/dmem_wr_arbiter.sv
// Purpose: round-robin arbiter granting whole write bursts from two requesters onto one data-memory write port.
// Latency: grant one cycle after req is sampled; each accepted beat appears on the memory port one cycle later.
// Backpressure: none on the beat path; ownership is released on last, on req drop, or forcibly after MAX_BURST beats.
module dmem_wr_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              wr_en0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              last0,
  output logic              gnt0,
  input  logic              req1,
  input  logic              wr_en1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  input  logic              last1,
  output logic              gnt1,
  output logic              en_w_datamem,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] MAX_M1  = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t            state, state_nxt;
  logic              rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]  beat_cnt, beat_cnt_nxt;
  logic              acc, acc_last, cur_req, ovr_nxt, room;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Beat selection from the owner, next-state, round-robin pointer and burst counter.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    acc          = 1'b0;
    acc_last     = 1'b0;
    acc_addr     = '0;
    acc_data     = '0;
    cur_req      = 1'b0;
    ovr_nxt      = 1'b0;
    // Counter saturates: once MAX_BURST beats are in, nothing more is accepted.
    room         = (beat_cnt < MAX_CNT);

    case (state)
      IDLE: begin
        // Sole requester wins; on contention rr_ptr picks the owner.
        if (req0 && (!req1 || !rr_ptr)) begin
          state_nxt = OWN0;
        end else if (req1) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        cur_req = req0;
        acc     = wr_en0 && room;
        if (acc) begin
          acc_addr = addr0;
          acc_data = data0;
          acc_last = last0;
        end
      end
      OWN1: begin
        cur_req = req1;
        acc     = wr_en1 && room;
        if (acc) begin
          acc_addr = addr1;
          acc_data = data1;
          acc_last = last1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (state == OWN0 || state == OWN1) begin
      if (acc) begin
        beat_cnt_nxt = beat_cnt + 1'b1;
      end
      // A last beat wins over the MAX_BURST limit, so a full-length burst ending
      // in last is a normal release without overrun.
      if ((acc && acc_last) || !cur_req) begin
        state_nxt    = IDLE;
        rr_ptr_nxt   = (state == OWN0);
        beat_cnt_nxt = '0;
      end else if (acc && beat_cnt == MAX_M1) begin
        state_nxt    = IDLE;
        rr_ptr_nxt   = (state == OWN0);
        beat_cnt_nxt = '0;
        ovr_nxt      = 1'b1;
      end
    end
  end

  // Arbitration state, pointer and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Registered grant/busy flags and the forwarded memory write; idle cycles drive zeros.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      en_w_datamem <= 1'b0;
      addr_out     <= '0;
      data_out     <= '0;
    end else begin
      gnt0         <= (state_nxt == OWN0);
      gnt1         <= (state_nxt == OWN1);
      busy         <= (state_nxt != IDLE);
      overrun      <= ovr_nxt;
      en_w_datamem <= acc;
      addr_out     <= acc_addr;
      data_out     <= acc_data;
    end
  end

endmodule

// File: tb/tb_dmem_wr_arbiter.sv
// Purpose: directed self-checking bench for dmem_wr_arbiter.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is cycle-exact.
module tb_dmem_wr_arbiter;

  localparam int MAX = 16;

  logic        clk;
  logic        reset;
  logic        req0, wr_en0, last0, gnt0;
  logic [31:0] addr0, data0;
  logic        req1, wr_en1, last1, gnt1;
  logic [31:0] addr1, data1;
  logic        en_w_datamem, busy, overrun;
  logic [31:0] addr_out, data_out;

  int n_chk;
  int n_fail;

  dmem_wr_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(MAX)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .wr_en0       (wr_en0),
    .addr0        (addr0),
    .data0        (data0),
    .last0        (last0),
    .gnt0         (gnt0),
    .req1         (req1),
    .wr_en1       (wr_en1),
    .addr1        (addr1),
    .data1        (data1),
    .last1        (last1),
    .gnt1         (gnt1),
    .en_w_datamem (en_w_datamem),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req0 = 0; wr_en0 = 0; last0 = 0; addr0 = '0; data0 = '0;
    req1 = 0; wr_en1 = 0; last1 = 0; addr1 = '0; data1 = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"},   en_w_datamem, 1'b0);
    chk({tag, "_addr"}, addr_out, 32'h0);
    chk({tag, "_data"}, data_out, 32'h0);
  endtask

  // Drives n consecutive beats for one requester and checks each forwarded write.
  task automatic send_burst(input int who, input int n, input logic [31:0] abase,
                            input logic [31:0] dbase, input bit use_last);
    logic [31:0] a, d;
    bit lst, wr_exp, gnt_exp, ovr_exp;
    for (int i = 0; i < n; i++) begin
      a   = abase + 32'(4 * i);
      d   = dbase + 32'(i);
      lst = use_last && (i == n - 1);
      if (who == 0) begin
        wr_en0 = 1; addr0 = a; data0 = d; last0 = lst;
      end else begin
        wr_en1 = 1; addr1 = a; data1 = d; last1 = lst;
      end
      step();
      wr_exp  = (i < MAX);
      gnt_exp = !(lst || i >= MAX - 1);
      ovr_exp = !use_last && (i == MAX - 1);
      chk("wr_en",   en_w_datamem, wr_exp);
      chk("wr_addr", addr_out, wr_exp ? a : 32'h0);
      chk("wr_data", data_out, wr_exp ? d : 32'h0);
      chk("gnt_own", (who == 0) ? gnt0 : gnt1, gnt_exp);
      chk("overrun", overrun, ovr_exp);
    end
    if (who == 0) begin
      wr_en0 = 0; last0 = 0;
    end else begin
      wr_en1 = 0; last1 = 0;
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clr_inputs();
    reset = 0;
    #3;
    chk("rst_gnt0", gnt0, 1'b0);
    chk("rst_gnt1", gnt1, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr",  overrun, 1'b0);
    chk_quiet("rst");
    @(negedge clk);
    reset = 1;
    step();
    chk("idle_busy", busy, 1'b0);

    // Single 16-beat SHA burst.
    req0 = 1;
    step();
    chk("sha_gnt0", gnt0, 1'b1);
    chk("sha_busy", busy, 1'b1);
    chk_quiet("sha_pre");
    send_burst(0, 16, 32'h0, 32'h0, 1'b1);
    chk("sha_busy_end", busy, 1'b0);
    req0 = 0;
    step();
    chk_quiet("sha_post");
    chk("sha_gnt0_post", gnt0, 1'b0);

    // Reset in the middle of a requester-1 burst.
    req1 = 1;
    step();
    chk("mid_gnt1", gnt1, 1'b1);
    wr_en1 = 1; addr1 = 32'h100; data1 = 32'h55;
    step();
    chk("mid_wr", en_w_datamem, 1'b1);
    addr1 = 32'h104; data1 = 32'h56;
    #2;
    reset = 0;
    #1;
    chk("mrst_gnt1", gnt1, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ovr",  overrun, 1'b0);
    chk_quiet("mrst");
    clr_inputs();
    @(negedge clk);
    reset = 1;
    step();
    chk_quiet("mrst_post");
    chk("mrst_post_gnt1", gnt1, 1'b0);

    // Simultaneous request after reset: requester 0 first, one idle cycle, then requester 1.
    req0 = 1; req1 = 1;
    step();
    chk("sim_gnt0", gnt0, 1'b1);
    chk("sim_gnt1", gnt1, 1'b0);
    send_burst(0, 4, 32'h200, 32'hA0, 1'b1);
    req0 = 0;
    chk("sim_turn_gnt1", gnt1, 1'b0);
    step();
    chk("sim_gnt1_up", gnt1, 1'b1);
    chk_quiet("sim_turn");
    send_burst(1, 4, 32'h300, 32'hB0, 1'b1);
    req1 = 0;

    // Round-robin with both requesters held high, 2-beat bursts.
    step();
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt0", gnt0, (k % 2) == 0);
      chk("rr_gnt1", gnt1, (k % 2) == 1);
      send_burst(k % 2, 2, 32'h400 + 32'(k * 16), 32'hC0 + 32'(k * 2), 1'b1);
    end

    // Overrun: 17 beats without last while requester 1 waits.
    step();
    chk("ovr_gnt0", gnt0, 1'b1);
    send_burst(0, 17, 32'h800, 32'hD0, 1'b0);
    req0 = 0;
    chk("ovr_next_gnt1", gnt1, 1'b1);
    req1 = 0;
    step();
    chk("ovr_drop_gnt1", gnt1, 1'b0);
    chk_quiet("ovr_drop");

    // Early req drop with a beat, plus a foreign beat from requester 1.
    req0 = 1;
    step();
    chk("ed_gnt0", gnt0, 1'b1);
    req0 = 0; wr_en0 = 1; addr0 = 32'h20; data0 = 32'hAA;
    wr_en1 = 1; addr1 = 32'h99; data1 = 32'hBB;
    step();
    chk("ed_en",   en_w_datamem, 1'b1);
    chk("ed_addr", addr_out, 32'h20);
    chk("ed_data", data_out, 32'hAA);
    chk("ed_gnt0", gnt0, 1'b0);
    chk("ed_busy", busy, 1'b0);
    clr_inputs();
    step();
    chk_quiet("ed_post");
    chk("ed_gnt1", gnt1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
